// File: rtl/seg7_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg7_scan_ctrl
//
// Time-multiplexed scan controller for a multi-digit 7-segment display.
// It places one nibble at a time on oDIG, which feeds a shared SEG7_LUT
// decoder, and drives the matching active-low digit anode.
// Each digit slot opens with a short all-dark interval. This keeps the
// previous digit's segments from ghosting onto the next anode.
// The controller also supports per-digit blinking and leading-zero
// suppression. The digit word is captured once per frame, so the display
// never shows a torn value.
//
// Ports
//   iCLK      in   1          system clock, rising edge
//   iRST_N    in   1          synchronous active-low reset
//   iEN       in   1          scan enable; low keeps the display dark
//   iDIGITS   in   4*NUM_DIG  nibble k = iDIGITS[4k+3:4k], k=0 rightmost
//   iBLINK    in   NUM_DIG    1 = digit k blinks
//   iLZ_SUPP  in   1          1 = suppress leading zeros
//   oDIG      out  4          nibble to SEG7_LUT.iDIG
//   oAN       out  NUM_DIG    digit enables, active-low
//   oDIG_IDX  out  IDX_W      index of the digit currently in its slot
//   oFRAME    out  1          one-cycle pulse at the start of each frame
// ---------------------------------------------------------------------------
module seg7_scan_ctrl #(
    parameter int NUM_DIG      = 4,
    parameter int DWELL        = 50000,
    parameter int BLANK        = 500,
    parameter int BLINK_FRAMES = 64,
    parameter int IDX_W        = 2
) (
    input  logic                   iCLK,
    input  logic                   iRST_N,
    input  logic                   iEN,
    input  logic [4*NUM_DIG-1:0]   iDIGITS,
    input  logic [NUM_DIG-1:0]     iBLINK,
    input  logic                   iLZ_SUPP,
    output logic [3:0]             oDIG,
    output logic [NUM_DIG-1:0]     oAN,
    output logic [IDX_W-1:0]       oDIG_IDX,
    output logic                   oFRAME
);

    localparam int SLOT_W = $clog2(DWELL);
    localparam int FC_W   = $clog2(BLINK_FRAMES + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BLANK = 2'd1;
    localparam logic [1:0] S_SHOW  = 2'd2;

    localparam logic [SLOT_W-1:0] BLANK_LAST = SLOT_W'(BLANK - 1);
    localparam logic [SLOT_W-1:0] DWELL_LAST = SLOT_W'(DWELL - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(NUM_DIG - 1);
    localparam logic [FC_W-1:0]   FC_FULL    = FC_W'(BLINK_FRAMES);

    logic [1:0]           state, state_n;
    logic [SLOT_W-1:0]    slot_cnt, slot_n;
    logic [IDX_W-1:0]     idx, idx_n;
    logic [4*NUM_DIG-1:0] snap, snap_n;
    logic [FC_W-1:0]      frame_cnt, fcnt_n;
    logic                 phase_hidden, phase_n;
    logic [3:0]           dig_n;
    logic [NUM_DIG-1:0]   an_n;
    logic                 frame_n;
    logic                 frame_start;

    logic [NUM_DIG-1:0]   lz_zero;
    logic                 dark;
    logic [NUM_DIG-1:0]   show_an;

    assign oDIG_IDX = idx;

    // lz_zero[k] is set when snapshot nibbles k..NUM_DIG-1 are all zero.
    always_comb begin
        logic acc;
        acc     = 1'b1;
        lz_zero = '0;
        for (int k = NUM_DIG - 1; k >= 0; k--) begin
            acc        = acc && (snap[4*k +: 4] == 4'h0);
            lz_zero[k] = acc;
        end
    end

    // Digit 0 is never blanked by leading-zero suppression, so a value of zero
    // still shows a single "0".
    assign dark    = (iBLINK[idx] && phase_hidden) ||
                     (iLZ_SUPP && (idx != '0) && lz_zero[idx]);
    assign show_an = dark ? '1 : ~(NUM_DIG'(1) << idx);

    always_comb begin
        // NOTE: every next-state value gets a default first, so no path through
        // the case/if tree can leave a value unassigned and infer a latch.
        state_n     = state;
        slot_n      = slot_cnt;
        idx_n       = idx;
        snap_n      = snap;
        fcnt_n      = frame_cnt;
        phase_n     = phase_hidden;
        dig_n       = oDIG;
        an_n        = '1;
        frame_n     = 1'b0;
        frame_start = 1'b0;

        if (!iEN) begin
            state_n = S_IDLE;
            slot_n  = '0;
            idx_n   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    state_n     = S_BLANK;
                    slot_n      = '0;
                    idx_n       = '0;
                    frame_start = 1'b1;
                end
                S_BLANK: begin
                    slot_n = slot_cnt + 1'b1;
                    if (slot_cnt == BLANK_LAST) begin
                        state_n = S_SHOW;
                        an_n    = show_an;
                    end
                end
                S_SHOW: begin
                    if (slot_cnt == DWELL_LAST) begin
                        state_n     = S_BLANK;
                        slot_n      = '0;
                        idx_n       = (idx == IDX_LAST) ? '0 : idx + 1'b1;
                        frame_start = (idx == IDX_LAST);
                        // Present the next nibble at the start of the dark
                        // interval so the decoder settles before the anode lights.
                        dig_n       = snap[{idx_n, 2'b00} +: 4];
                    end else begin
                        slot_n = slot_cnt + 1'b1;
                        an_n   = show_an;
                    end
                end
                default: begin
                    state_n = S_IDLE;
                    slot_n  = '0;
                    idx_n   = '0;
                end
            endcase
        end

        if (frame_start) begin
            snap_n  = iDIGITS;
            dig_n   = iDIGITS[3:0];
            frame_n = 1'b1;
            // frame_cnt counts frames already shown in the current phase. A new
            // frame that finds it full becomes the first frame of the other phase.
            if (frame_cnt == FC_FULL) begin
                fcnt_n  = FC_W'(1);
                phase_n = ~phase_hidden;
            end else begin
                fcnt_n = frame_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state        <= S_IDLE;
            slot_cnt     <= '0;
            idx          <= '0;
            // NOTE: the snapshot is an ordinary register, not a RAM. It is reset
            // so that oDIG and leading-zero blanking start from a defined value.
            snap         <= '0;
            frame_cnt    <= '0;
            phase_hidden <= 1'b0;
            oDIG         <= 4'h0;
            oAN          <= '1;
            oFRAME       <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments. This way every
            // flop samples its pre-edge value regardless of statement order.
            state        <= state_n;
            slot_cnt     <= slot_n;
            idx          <= idx_n;
            snap         <= snap_n;
            frame_cnt    <= fcnt_n;
            phase_hidden <= phase_n;
            oDIG         <= dig_n;
            oAN          <= an_n;
            oFRAME       <= frame_n;
        end
    end

endmodule
